// File: rtl/result_pack.sv
// Packs a captured 8x8 result tile into 32 AXI write beats of 256 bits; first beat 1 cycle after start.
// Beats advance only on beat_valid && beat_ready; a stalled beat holds its data, burst_num and beat_last.
package params;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;

  typedef enum logic [1:0] {
    M32N8      = 2'd0,
    M16N16     = 2'd1,
    M8N32      = 2'd2,
    RC_ILLEGAL = 2'd3
  } rc_t;
endpackage

module result_pack (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  params::type_t          data_type,
  input  params::rc_t            rc,
  input  logic [7:0][7:0][31:0]  tile_in,
  output logic [255:0]           beat_data,
  output logic [4:0]             burst_num,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic                   beat_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q;
  logic [4:0]             burst_q;
  logic                   last_q;
  logic                   done_q;
  logic                   err_q;
  logic [7:0][7:0][31:0]  tile_q;
  params::type_t          dtype_q;
  params::rc_t            rc_q;

  logic [2:0]             row_sel;
  logic [7:0][31:0]       row_w;
  logic [255:0]           pack_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tile_q  <= '0;
      dtype_q <= params::FP32;
      rc_q    <= params::M32N8;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (rc == params::RC_ILLEGAL) begin
              err_q <= 1'b1;
            end else begin
              tile_q  <= tile_in;
              dtype_q <= data_type;
              rc_q    <= rc;
              burst_q <= '0;
              last_q  <= 1'b0;
              state_q <= SEND;
            end
          end
        end
        SEND: begin
          // last_q marks beat 31 so the exit decision needs no wide compare
          if (beat_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              burst_q <= '0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              burst_q <= burst_q + 5'd1;
              last_q  <= (burst_q == 5'd30);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    row_sel = burst_q[2:0];
    case (rc_q)
      params::M32N8:  row_sel = burst_q[4:2];
      params::M16N16: row_sel = burst_q[3:1];
      default:        row_sel = burst_q[2:0];
    endcase
  end

  assign row_w = tile_q[row_sel];

  // Narrow types keep only the low element bits and leave the upper beat lanes zero
  always_comb begin
    pack_w = '0;
    for (int i = 0; i < 8; i++) begin
      case (dtype_q)
        params::FP32: pack_w[32*i +: 32] = row_w[i];
        params::FP16: pack_w[16*i +: 16] = row_w[i][15:0];
        params::INT8: pack_w[8*i  +: 8]  = row_w[i][7:0];
        default:      pack_w[4*i  +: 4]  = row_w[i][3:0];
      endcase
    end
  end

  assign beat_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign beat_last  = last_q;
  assign burst_num  = beat_valid ? burst_q : 5'd0;
  assign beat_data  = beat_valid ? pack_w : 256'd0;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/result_pack.md
RESULT_PACK -- requirements
Module: result_pack

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: the clock port is clk, the reset port is rst_n, and there are no other clocks.
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to pack one result tile.
- data_type  input  params::type_t  element type: FP32, FP16, INT8 or INT4.
- rc  input  params::rc_t  shape: 00 = M32N8, 01 = M16N16, 10 = M8N32, 11 = illegal.
- tile_in  input  [7:0][7:0][31:0]  systolic result array, indexed [row][col].
- beat_data  output  256  AXI write-beat payload.
- burst_num  output  5  index of the current beat, 0..31.
- beat_valid  output  1  beat_data and burst_num are valid.
- beat_ready  input  1  downstream accepts the beat.
- beat_last  output  1  marks beat 31.
- busy  output  1  a tile is in flight.
- done  output  1  one-cycle pulse after the last beat is accepted.
- err  output  1  one-cycle pulse when a start carries rc=11.

Function
REQ-003 SHALL implement the state machine IDLE -> SEND -> IDLE; busy SHALL be 1 exactly when the state is SEND.
REQ-004 In IDLE, on start=1 with rc != 11:
- SHALL capture tile_in, data_type and rc into internal registers;
- SHALL clear the beat counter to 0;
- SHALL enter SEND on the next edge.
REQ-005 In IDLE, on start=1 with rc=11:
- SHALL pulse err for one cycle;
- SHALL stay in IDLE;
- SHALL emit no beats and no done.
REQ-006 SHALL ignore start while busy=1; the captured tile SHALL NOT change.
REQ-007 SHALL drive beat_valid=1 from the first cycle after an accepted start, giving a start-to-first-valid latency of 1 cycle.
REQ-008 SHALL hold beat_valid, beat_data, burst_num and beat_last stable while beat_valid=1 and beat_ready=0.
REQ-009 On beat_valid and beat_ready both 1:
- SHALL advance burst_num by 1;
- beat 31 SHALL be the final beat of the tile, with no wrap-around within a tile.
REQ-010 SHALL assert beat_last exactly while burst_num=31 and beat_valid=1.
REQ-011 When beat 31 is accepted, SHALL return to IDLE on the next edge, deassert beat_valid and pulse done for that one IDLE cycle.
REQ-012 A start arriving in the same cycle as done SHALL be accepted.
REQ-013 With beat_ready held at 1, SHALL issue 32 beats on 32 consecutive cycles.
REQ-014 SHALL select source row r from burst_num b according to rc:
- rc=00: r = b[4:2];
- rc=01: r = b[3:1];
- rc=10: r = b[2:0].
REQ-015 SHALL pack beat_data from row r, for column i = 0..7, according to data_type:
- FP32: beat_data[32i+:32] = tile[r][i][31:0].
- FP16: beat_data[16i+:16] = tile[r][i][15:0]; bits 255:128 = 0.
- INT8: beat_data[8i+:8] = tile[r][i][7:0]; bits 255:64 = 0.
- INT4: beat_data[4i+:4] = tile[r][i][3:0]; bits 255:32 = 0.
REQ-016 SHALL truncate narrower types, discarding upper element bits, with no saturation or rounding.
REQ-017 SHALL drive beat_data and burst_num to 0 whenever beat_valid=0.
REQ-018 SHALL make beat_data depend only on the captured registers, never on live tile_in.

Reset
REQ-019 While rst_n=0, SHALL immediately force:
- state to IDLE;
- beat_valid, beat_last, busy, done and err to 0;
- burst_num and beat_data to 0;
- the captured tile, data_type and rc to 0.
REQ-020 Reset asserted mid-tile SHALL abort the tile with no done pulse.
REQ-021 After reset releases, the block SHALL accept start on the first rising edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- FP32, rc=00, tile[r][i] = {r,i,24'h0}, beat_ready=1 -> 32 consecutive beats; beat b carries row b[4:2]; beat_last on beat 31; done on the following cycle.
- INT4, rc=10, tile[r][i] = 32'hFFFF_FFF0 + i -> beat_data[31:0] = 32'h7654_3210 on every beat; bits 255:32 = 0.
- FP16, rc=01, beat_ready toggling 1,0,0,1,... -> beat_data and burst_num stable while stalled; 32 handshakes total; burst_num sequence 0..31 without skips.
- start with rc=11 -> err pulses for one cycle; busy stays 0; no beat_valid.
- start pulsed again at beat 10, with tile_in changed -> start ignored; beats 11..31 still carry the originally captured data.
- rst_n low at beat 5 -> all outputs 0 asynchronously; no done; a new start after release restarts at burst_num=0.
